hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Detects three conditions and resolves them in priority order:
  - data-memory wait (highest),
  - EX-stage control-flow redirect,
  - load-use hazard (lowest).
- Holds a small FSM for multi-cycle memory waits, a timeout watchdog, and saturating performance counters.
- Sits beside the datapath. Its outputs are combinational in cycle N and take effect at the stage-register clock edge that ends cycle N.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles before the watchdog fires (≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low; the block is in reset while rst=0.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX.
- mem_req  in  1  MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID.
- stall_id_ex  out  1  hold ID/EX.
- stall_ex_mem  out  1  hold EX/MEM.
- flush_if_id  out  1  zero IF/ID.
- flush_id_ex  out  1  zero ID/EX (insert bubble).
- flush_mem_wb  out  1  zero MEM/WB (insert bubble).
- mem_err  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1, saturating.
- redirect_cnt  out  CNT_W  count of accepted redirects, saturating.

Behaviour:
- Reset values (rst=0):
  - FSM in RUN, wait counter 0.
  - mem_err=0, both performance counters 0.
  - All stall/flush outputs 0. They are combinational but gated by reset.
- FSM state RUN:
  - A memory wait is when mem_req=1 and dmem_ready=0.
  - On a memory wait, assert stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and flush_mem_wb. Next state is MEM_WAIT, wait counter set to 1.
  - A memory wait suppresses redirect and load-use actions in that cycle. Their inputs remain held by the stalled registers and are re-evaluated after release.
- FSM state MEM_WAIT:
  - While dmem_ready=0, keep the same five outputs asserted and increment the wait counter.
  - When dmem_ready=1, deassert all stalls in that same cycle and return to RUN.
  - In the release cycle, redirect and load-use are evaluated normally.
- Watchdog:
  - In MEM_WAIT with dmem_ready=0 and wait counter = MEM_TIMEOUT, set mem_err (sticky until reset) and force the FSM to RUN.
  - The stall outputs drop in that same cycle.
- Redirect (state RUN, no memory wait, ex_redirect=1):
  - Assert flush_if_id and flush_id_ex. stall_pc=0, so the PC loads the target.
  - Load-use is ignored because the ID instruction is being squashed.
  - redirect_cnt increments.
- Load-use (state RUN, no memory wait, no redirect):
  - Hazard when ex_mem_read=1, ex_rd≠0, and (id_uses_rs1 and id_rs1=ex_rd) or (id_uses_rs2 and id_rs2=ex_rd).
  - Assert stall_pc, stall_if_id and flush_id_ex for exactly one cycle. The inserted bubble clears ex_mem_read on the next cycle.
- No stall or flush is ever raised for register x0.
- Performance counters:
  - Update on the clock edge.
  - Saturate at all-ones with no wrap.
  - stall_cycles counts every cycle with stall_pc=1, including the memory-wait entry cycle.
- Asynchronous reset asserted mid-wait: the FSM returns to RUN immediately and all outputs read 0 while rst=0.

Decomposition:
- Shared package/header: register-index width (5), FSM state encodings (RUN, MEM_WAIT), CNT_W default.
- One sub-module is natural: sat_counter (width parameter, inc, synchronous clear, async active-low reset), instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of stall_pc=stall_if_id=flush_id_ex=1; stall_cycles 0→1.
- x0 load: ex_mem_read=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 → all control outputs 0.
- Redirect plus load-use in the same cycle: ex_redirect=1 with a load-use match → flush_if_id=flush_id_ex=1, stall_pc=0; redirect_cnt=1.
- Memory wait: mem_req=1, dmem_ready low for 3 cycles then high → four stalls and flush_mem_wb high for 3 cycles, low in the 4th; stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4, dmem_ready held 0 → mem_err=1 after the 4th wait-counter match; stalls drop that cycle; mem_err stays 1 until rst=0.
- Reset mid-wait: drive rst=0 during MEM_WAIT → outputs 0 immediately, counters 0; after release, with no request pending (mem_req=0), the FSM stays in RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // Bundle of every stage-register control line, MSB first as listed.
    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_mem_wb;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE = '0;

    // Freeze everything upstream of MEM and feed bubbles into WB.
    localparam hz_ctrl_t CTRL_MEM_WAIT = '{
        stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1, stall_ex_mem: 1'b1,
        flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_mem_wb: 1'b1
    };

    // Squash the two younger instructions; PC is free to load the target.
    localparam hz_ctrl_t CTRL_REDIRECT = '{
        stall_pc: 1'b0, stall_if_id: 1'b0, stall_id_ex: 1'b0, stall_ex_mem: 1'b0,
        flush_if_id: 1'b1, flush_id_ex: 1'b1, flush_mem_wb: 1'b0
    };

    // Hold fetch/decode one cycle and push a bubble into EX.
    localparam hz_ctrl_t CTRL_LOAD_USE = '{
        stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b0, stall_ex_mem: 1'b0,
        flush_if_id: 1'b0, flush_id_ex: 1'b1, flush_mem_wb: 1'b0
    };

    // True when the ID instruction reads a register a load in EX is about to write.
    // x0 is never a hazard because it is hard-wired to zero.
    function automatic logic load_use_hit(
        input logic                 ex_mem_read,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic [REG_IDX_W-1:0] id_rs1,
        input logic [REG_IDX_W-1:0] id_rs2,
        input logic                 id_uses_rs1,
        input logic                 id_uses_rs2
    );
        logic rs1_hit;
        logic rs2_hit;
        rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
        return ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Latency: count updates on the clock edge after i_inc; clear wins over increment.
// Backpressure: none; i_inc is sampled every cycle.
module hazard_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;
    assign o_cnt  = r_cnt;

    // Count qualified events, holding at the maximum value once reached.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: stall/flush generation for a 5-stage pipeline (mem wait > redirect > load-use).
// Latency: control outputs are combinational in the cycle the condition is seen.
// Backpressure: a data-memory wait freezes PC..EX/MEM until dmem_ready or watchdog expiry.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_mem_read,
    input  logic                 i_ex_redirect,
    input  logic                 i_mem_req,
    input  logic                 i_dmem_ready,
    output logic                 o_stall_pc,
    output logic                 o_stall_if_id,
    output logic                 o_stall_id_ex,
    output logic                 o_stall_ex_mem,
    output logic                 o_flush_if_id,
    output logic                 o_flush_id_ex,
    output logic                 o_flush_mem_wb,
    output logic                 o_mem_err,
    output logic [CNT_W-1:0]     o_stall_cycles,
    output logic [CNT_W-1:0]     o_redirect_cnt
);

    // Wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;

    logic     w_in_wait;
    logic     w_wait_start;
    logic     w_timeout;
    logic     w_wait_hold;
    logic     w_mem_stall;
    logic     w_redirect;
    logic     w_load_use;
    hz_ctrl_t w_ctrl;
    hz_ctrl_t w_ctrl_gated;

    assign w_in_wait    = (r_state == ST_MEM_WAIT);
    assign w_wait_start = !w_in_wait && i_mem_req && !i_dmem_ready;
    // Watchdog expiry releases the pipeline in the same cycle it fires.
    assign w_timeout    = w_in_wait && !i_dmem_ready && (r_wait_cnt == WAIT_LIMIT);
    assign w_wait_hold  = w_in_wait && !i_dmem_ready && !w_timeout;
    assign w_mem_stall  = w_wait_start || w_wait_hold;

    // While memory stalls, redirect/load-use inputs sit in frozen registers and
    // are simply re-evaluated once the wait releases.
    assign w_redirect = !w_mem_stall && i_ex_redirect;
    assign w_load_use = !w_mem_stall && !i_ex_redirect &&
                        load_use_hit(i_ex_mem_read, i_ex_rd, i_id_rs1, i_id_rs2,
                                     i_id_uses_rs1, i_id_uses_rs2);

    // Priority select of the stage-register control pattern.
    always_comb begin
        w_ctrl = CTRL_NONE;
        if (w_mem_stall) begin
            w_ctrl = CTRL_MEM_WAIT;
        end else if (w_redirect) begin
            w_ctrl = CTRL_REDIRECT;
        end else if (w_load_use) begin
            w_ctrl = CTRL_LOAD_USE;
        end
    end

    // Outputs are combinational, so force them low while reset is held.
    assign w_ctrl_gated = i_rst ? w_ctrl : CTRL_NONE;

    assign o_stall_pc     = w_ctrl_gated.stall_pc;
    assign o_stall_if_id  = w_ctrl_gated.stall_if_id;
    assign o_stall_id_ex  = w_ctrl_gated.stall_id_ex;
    assign o_stall_ex_mem = w_ctrl_gated.stall_ex_mem;
    assign o_flush_if_id  = w_ctrl_gated.flush_if_id;
    assign o_flush_id_ex  = w_ctrl_gated.flush_id_ex;
    assign o_flush_mem_wb = w_ctrl_gated.flush_mem_wb;
    assign o_mem_err      = r_mem_err;

    // Memory-wait FSM with wait counter and sticky watchdog flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wait_start) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_dmem_ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst),
        .i_clr   (1'b0),
        .i_inc   (w_ctrl_gated.stall_pc),
        .o_cnt   (o_stall_cycles)
    );

    hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_redirect_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst),
        .i_clr   (1'b0),
        .i_inc   (w_redirect),
        .o_cnt   (o_redirect_cnt)
    );

endmodule
